fwd_hazard_unit: RTL and testbench
==================================

FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

Interface
REQ-001 SHALL provide parameter AW, default 5, register-address width.
REQ-002 SHALL provide parameter DEPTH, default 3, in-flight writer stages tracked (legal range 2..7).
REQ-003 SHALL provide parameter NSRC, default 2, source-operand channels.
REQ-004 SHALL provide parameter TMO, default 15, memory-wait timeout in cycles (legal range 1..255).
REQ-005 SHALL derive SW = clog2(DEPTH+1), the select width.
REQ-006 SHALL have a single clock and an asynchronous active-low reset.
REQ-007 SHALL have these ports, as name, direction, width, meaning:
 - clk_i  in  1  clock, rising edge.
 - rst_n  in  1  async active-low reset.
 - issue_valid_i  in  1  instruction leaving EX this cycle.
 - issue_rd_i  in  AW  its destination.
 - issue_wen_i  in  1  it writes a register.
 - issue_load_i  in  1  it is a load.
 - flush_i  in  1  kill the issuing instruction.
 - src_addr_i  in  NSRC*AW  EX-stage sources, channel j at bits [j*AW+:AW].
 - src_used_i  in  NSRC  channel j source is read.
 - mem_ready_i  in  1  load data returned this cycle.
 - fwd_sel_o  out  NSRC*SW  per-channel forward select.
 - stall_o  out  1  hold fetch/decode/EX.
 - issue_ready_o  out  1  issue accepted this cycle.
 - timeout_o  out  1  sticky memory-wait timeout.
 - stall_cnt_o  out  16  saturating count of stall cycles.

Function
REQ-008 SHALL hold stage array st[0..DEPTH-1], each entry {valid, rd, wen, load}; st[0] is youngest (MEM), st[1] is WB, higher indices are write-back buffers.
REQ-009 SHALL compute, for each channel j: if src_used_i[j]=1 and the address is nonzero, fwd_sel = k+1 for the smallest k with st[k].valid & st[k].wen & st[k].rd == address; else 0.
REQ-010 SHALL treat the youngest matching stage as having priority over all older matches.
REQ-011 SHALL never match address 0.
REQ-012 SHALL derive fwd_sel_o combinationally from registered state and src inputs only.
REQ-013 SHALL define mem_stall = st[0].valid & st[0].load & ~mem_ready_i.
REQ-014 SHALL define lu_stall = ~mem_stall & st[0].valid & st[0].load & st[0].wen & (any used nonzero channel matches st[0].rd).
REQ-015 SHALL drive stall_o = mem_stall | lu_stall and issue_ready_o = ~stall_o.
REQ-016 SHALL, on mem_stall, freeze all stages: no shift and no issue capture.
REQ-017 SHALL, on lu_stall, shift st[k] <= st[k-1] for k≥1, write a bubble (valid=0) into st[0], and not capture the issue.
REQ-018 SHALL, when there is no stall, shift all stages and load st[0] <= {issue_valid_i & ~flush_i, issue_rd_i, issue_wen_i, issue_load_i}.
REQ-019 SHALL ignore flush_i during a freeze.
REQ-020 SHALL drop the oldest stage on every shift.
REQ-021 SHALL implement the FSM as follows:
 - States RUN and WAIT.
 - RUN->WAIT when mem_stall.
 - WAIT->RUN in the cycle mem_ready_i=1.
 - A wait counter (8 bits) clears on entering WAIT and increments each WAIT cycle.
REQ-022 SHALL set timeout_o when the wait counter reaches TMO while in WAIT; timeout_o stays set until reset.
REQ-023 SHALL keep the pipeline frozen after a timeout until mem_ready_i.
REQ-024 SHALL increment stall_cnt_o each cycle stall_o=1, saturating at 16'hFFFF.
REQ-025 SHALL apply the resulting load-use behaviour after a mem_stall clears: a dependent instruction still sees lu_stall in that release cycle, giving exactly one bubble.

Reset
REQ-026 SHALL, while rst_n=0 (asynchronously):
 - Clear all st[k].valid.
 - Set FSM=RUN.
 - Set wait counter=0, timeout_o=0, stall_cnt_o=0.
REQ-027 SHALL, during reset and in the first cycle after it: fwd_sel_o=0, stall_o=0, issue_ready_o=1.
REQ-028 SHALL abandon any WAIT or lu_stall in progress when reset is asserted mid-operation; no stale forward survives reset.

Verification
REQ-029 SHALL cover an EX->EX forward: issue add rd=3, next cycle src0=3 used -> fwd_sel ch0=1. Following cycle (rd=3 now in st[1]) -> fwd_sel=2.
REQ-030 SHALL cover priority and r0: st[0].rd=5, st[1].rd=5, src1=5 -> fwd_sel ch1=1. src0=0 with an st[0] writer to r0 -> ch0=0.
REQ-031 SHALL cover load-use: issue load rd=7 with mem_ready_i=1, next cycle src0=7 -> stall_o=1 for exactly 1 cycle, then fwd_sel ch0=2. stall_cnt_o=1.
REQ-032 SHALL cover a memory wait: load in st[0], mem_ready_i=0 for 4 cycles -> stall_o=1 for 4 cycles, stages frozen, flush_i ignored. Release on ready.
REQ-033 SHALL cover timeout: TMO=15, mem_ready_i held 0 for 20 cycles -> timeout_o rises on the 15th WAIT cycle and stays 1 after ready. rst_n pulse mid-WAIT -> all outputs at reset values.
REQ-034 SHALL cover saturation: force 70000 stall cycles -> stall_cnt_o=16'hFFFF, with no wrap.

Source files
------------

// File: rtl/fwd_hazard_unit.sv
// rtl/fwd_hazard_unit.sv - operand forwarding select and load/memory hazard stall control
module fwd_hazard_unit #(
  parameter int AW    = 5,
  parameter int DEPTH = 3,
  parameter int NSRC  = 2,
  parameter int TMO   = 15,
  localparam int SW   = $clog2(DEPTH + 1)
) (
  input  logic               clk_i,
  input  logic               rst_n,
  input  logic               issue_valid_i,
  input  logic [AW-1:0]      issue_rd_i,
  input  logic               issue_wen_i,
  input  logic               issue_load_i,
  input  logic               flush_i,
  input  logic [NSRC*AW-1:0] src_addr_i,
  input  logic [NSRC-1:0]    src_used_i,
  input  logic               mem_ready_i,
  output logic [NSRC*SW-1:0] fwd_sel_o,
  output logic               stall_o,
  output logic               issue_ready_o,
  output logic               timeout_o,
  output logic [15:0]        stall_cnt_o
);

  typedef struct packed {
    logic          valid;
    logic [AW-1:0] rd;
    logic          wen;
    logic          load;
  } stage_t;

  typedef enum logic {S_RUN, S_WAIT} state_t;

  stage_t      st [DEPTH];
  state_t      state, state_n;
  logic [7:0]  wcnt;
  logic        timeout_q;
  logic        tmo_hit;
  logic [15:0] stall_cnt;
  logic        mem_stall, lu_stall, lu_match;
  logic [AW-1:0] addr;

  // Scan oldest to youngest so the youngest matching stage overwrites older ones.
  always_comb begin
    fwd_sel_o = '0;
    lu_match  = 1'b0;
    addr      = '0;
    for (int j = 0; j < NSRC; j++) begin
      addr = src_addr_i[j*AW +: AW];
      if (src_used_i[j] && addr != '0) begin
        for (int k = DEPTH - 1; k >= 0; k--) begin
          if (st[k].valid && st[k].wen && st[k].rd == addr)
            fwd_sel_o[j*SW +: SW] = SW'(k + 1);
        end
        if (st[0].valid && st[0].wen && st[0].rd == addr)
          lu_match = 1'b1;
      end
    end
  end

  assign mem_stall     = st[0].valid & st[0].load & ~mem_ready_i;
  assign lu_stall      = ~mem_stall & st[0].valid & st[0].load & lu_match;
  assign stall_o       = mem_stall | lu_stall;
  assign issue_ready_o = ~stall_o;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) st[k] <= '0;
    end else if (!mem_stall) begin
      for (int k = DEPTH - 1; k >= 1; k--) st[k] <= st[k-1];
      if (lu_stall)
        st[0] <= '0;
      else
        st[0] <= '{valid: issue_valid_i & ~flush_i, rd: issue_rd_i,
                   wen: issue_wen_i, load: issue_load_i};
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      S_RUN:   if (mem_stall)   state_n = S_WAIT;
      S_WAIT:  if (mem_ready_i) state_n = S_RUN;
      default: state_n = S_RUN;
    endcase
  end

  // wcnt holds the number of WAIT cycles already elapsed, so the TMO-th WAIT cycle sees TMO-1.
  assign tmo_hit     = (state == S_WAIT) && (wcnt == 8'(TMO - 1));
  assign timeout_o   = timeout_q | tmo_hit;
  assign stall_cnt_o = stall_cnt;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_RUN;
      wcnt      <= '0;
      timeout_q <= 1'b0;
      stall_cnt <= '0;
    end else begin
      state <= state_n;
      if (state == S_RUN)
        wcnt <= '0;
      else if (wcnt != 8'hFF)
        wcnt <= wcnt + 8'd1;
      if (tmo_hit)
        timeout_q <= 1'b1;
      if (stall_o && stall_cnt != 16'hFFFF)
        stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb/tb_fwd_hazard_unit.sv - directed and random checks of fwd_hazard_unit against a queue model
module tb_fwd_hazard_unit;
  localparam int AW = 5, DEPTH = 3, NSRC = 2, TMO = 15, SW = 2;

  logic                clk_i = 1'b0;
  logic                rst_n = 1'b1;
  logic                issue_valid_i = 1'b0;
  logic [AW-1:0]       issue_rd_i = '0;
  logic                issue_wen_i = 1'b0;
  logic                issue_load_i = 1'b0;
  logic                flush_i = 1'b0;
  logic [NSRC*AW-1:0]  src_addr_i = '0;
  logic [NSRC-1:0]     src_used_i = '0;
  logic                mem_ready_i = 1'b1;
  logic [NSRC*SW-1:0]  fwd_sel_o;
  logic                stall_o, issue_ready_o, timeout_o;
  logic [15:0]         stall_cnt_o;

  fwd_hazard_unit #(.AW(AW), .DEPTH(DEPTH), .NSRC(NSRC), .TMO(TMO)) dut (
    .clk_i(clk_i), .rst_n(rst_n), .issue_valid_i(issue_valid_i), .issue_rd_i(issue_rd_i),
    .issue_wen_i(issue_wen_i), .issue_load_i(issue_load_i), .flush_i(flush_i),
    .src_addr_i(src_addr_i), .src_used_i(src_used_i), .mem_ready_i(mem_ready_i),
    .fwd_sel_o(fwd_sel_o), .stall_o(stall_o), .issue_ready_o(issue_ready_o),
    .timeout_o(timeout_o), .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { bit v; int rd; bit wen; bit ld; } ent_t;

  int   n_cmp = 0, n_bad = 0;
  ent_t pipe[$];
  bit   in_wait, tmo_s;
  int   waits_done, scnt;
  logic [31:0] o_sel0, o_sel1, o_stall, o_tmo, o_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    pipe.delete();
    repeat (DEPTH) pipe.push_back('{0, 0, 0, 0});
    in_wait = 0; tmo_s = 0; waits_done = 0; scnt = 0;
  endtask

  function automatic int m_sel(int a, bit used);
    if (!used || a == 0) return 0;
    foreach (pipe[k]) if (pipe[k].v && pipe[k].wen && pipe[k].rd == a) return k + 1;
    return 0;
  endfunction

  // One clock cycle: drive, compare with the model, then advance the model across the edge.
  task automatic cyc(input bit v, input int rd, input bit wen, input bit ld, input bit fl,
                     input int s0, input int s1, input bit [1:0] used, input bit rdy);
    bit ms, lu, etmo;
    ent_t n;
    issue_valid_i = v; issue_rd_i = AW'(rd); issue_wen_i = wen; issue_load_i = ld;
    flush_i = fl; src_addr_i = {AW'(s1), AW'(s0)}; src_used_i = used; mem_ready_i = rdy;
    #3;
    ms = pipe[0].v && pipe[0].ld && !rdy;
    lu = !ms && pipe[0].v && pipe[0].ld && pipe[0].wen &&
         ((used[0] && s0 != 0 && s0 == pipe[0].rd) || (used[1] && s1 != 0 && s1 == pipe[0].rd));
    etmo = tmo_s || (in_wait && waits_done + 1 >= TMO);
    o_sel0 = 32'(fwd_sel_o[1:0]); o_sel1 = 32'(fwd_sel_o[3:2]);
    o_stall = 32'(stall_o); o_tmo = 32'(timeout_o); o_cnt = 32'(stall_cnt_o);
    check("fwd0", fwd_sel_o[1:0], m_sel(s0, used[0]));
    check("fwd1", fwd_sel_o[3:2], m_sel(s1, used[1]));
    check("stall", stall_o, ms | lu);
    check("ready", issue_ready_o, !(ms | lu));
    check("timeout", timeout_o, etmo);
    check("stall_cnt", stall_cnt_o, scnt);
    if (ms | lu) scnt = (scnt < 65535) ? scnt + 1 : scnt;
    if (in_wait) begin
      waits_done++;
      if (waits_done >= TMO) tmo_s = 1;
    end
    if (!in_wait && ms) waits_done = 0;
    in_wait = ms;
    if (!ms) begin
      n = lu ? '{0, 0, 0, 0} : '{v && !fl, rd, wen, ld};
      void'(pipe.pop_back());
      pipe.push_front(n);
    end
    @(posedge clk_i); #1;
  endtask

  task automatic reset_check(input string tag);
    rst_n = 1'b0;
    #1;
    check({tag, "_fwd"}, fwd_sel_o, 0);
    check({tag, "_stall"}, stall_o, 0);
    check({tag, "_ready"}, issue_ready_o, 1);
    check({tag, "_timeout"}, timeout_o, 0);
    check({tag, "_cnt"}, stall_cnt_o, 0);
    model_reset();
    @(negedge clk_i);
    rst_n = 1'b1;
    @(posedge clk_i); #1;
  endtask

  initial begin
    model_reset();
    #2;
    reset_check("rst0");

    // EX->EX then WB forward
    cyc(1, 3, 1, 0, 0, 0, 0, 2'b00, 1);
    cyc(0, 0, 0, 0, 0, 3, 0, 2'b01, 1); check("ex_ex_fwd", o_sel0, 1);
    cyc(0, 0, 0, 0, 0, 3, 0, 2'b01, 1); check("wb_fwd", o_sel0, 2);

    // youngest priority, and r0 never forwards
    cyc(1, 5, 1, 0, 0, 0, 0, 2'b00, 1);
    cyc(1, 5, 1, 0, 0, 0, 0, 2'b00, 1);
    cyc(0, 0, 0, 0, 0, 0, 5, 2'b10, 1); check("prio", o_sel1, 1);
    cyc(1, 0, 1, 0, 0, 0, 0, 2'b00, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 2'b01, 1); check("r0", o_sel0, 0);

    // load-use: one bubble then forward from WB
    reset_check("rst1");
    cyc(1, 7, 1, 1, 0, 0, 0, 2'b00, 1);
    cyc(1, 8, 1, 0, 0, 7, 0, 2'b01, 1); check("lu_stall", o_stall, 1);
    cyc(1, 8, 1, 0, 0, 7, 0, 2'b01, 1);
    check("lu_release", o_stall, 0); check("lu_fwd", o_sel0, 2); check("lu_cnt", o_cnt, 1);

    // memory wait with flush ignored, release still load-use stalls once
    cyc(1, 9, 1, 1, 0, 0, 0, 2'b00, 1);
    for (int i = 0; i < 4; i++) begin
      cyc(1, 12, 1, 0, 1, 0, 9, 2'b10, 0);
      check("mw_stall", o_stall, 1); check("mw_frozen", o_sel1, 1);
    end
    cyc(1, 12, 1, 0, 0, 0, 9, 2'b10, 1); check("mw_release_bubble", o_stall, 1);
    cyc(1, 12, 1, 0, 0, 0, 9, 2'b10, 1); check("mw_after", o_stall, 0); check("mw_fwd", o_sel1, 2);

    // timeout on the 15th WAIT cycle, sticky after ready
    reset_check("rst2");
    cyc(1, 10, 1, 1, 0, 0, 0, 2'b00, 1);
    for (int s = 1; s <= 20; s++) begin
      cyc(0, 0, 0, 0, 0, 10, 0, 2'b01, 0);
      if (s == 15) check("tmo_before", o_tmo, 0);
      if (s == 16) check("tmo_rise", o_tmo, 1);
    end
    cyc(0, 0, 0, 0, 0, 0, 0, 2'b00, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 2'b00, 1); check("tmo_sticky", o_tmo, 1);

    // reset asserted mid-WAIT with a live dependent source
    cyc(1, 11, 1, 1, 0, 0, 0, 2'b00, 1);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 11, 11, 2'b11, 0);
    reset_check("rst_mid_wait");

    // randomized traffic over a small register set to provoke hazards
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 3) != 0,
          $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
          $urandom_range(0, 3), $urandom_range(0, 3), 2'($urandom_range(0, 3)),
          $urandom_range(0, 2) != 0);

    // stall counter saturation
    reset_check("rst3");
    cyc(1, 1, 1, 1, 0, 0, 0, 2'b00, 1);
    for (int i = 0; i < 70000; i++) cyc(0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
    check("cnt_sat", o_cnt, 32'hFFFF);
    cyc(0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
    check("cnt_nowrap", o_cnt, 32'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
